multicycle_cu: RTL and testbench

Multi-cycle control unit for the MIPS-subset core: a Moore/Mealy FSM that sequences fetch, decode, execute, memory and write-back over several cycles against a shared, variable-latency memory port. It replaces single-cycle combinational decode, adds a ready/request memory handshake, `bne`/`andi`/`ori`/`addi`/`jal` support, illegal-opcode detection and a retired-instruction counter. It sits beside the datapath, driving its register enables and muxes from the instruction register and ALU zero flag.

---
 rtl/multicycle_cu.sv | 191 +++++++++++++++++++
 tb/tb_multicycle_cu.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_cu.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB against a
// variable-latency memory port and counts retired instructions.
module multicycle_cu #(
    parameter int unsigned ALU_OP_W = 3,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         inst,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                ir_we,
    output logic                pc_we,
    output logic [1:0]          pc_src,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                alu_src_imm,
    output logic                reg_we,
    output logic [1:0]          reg_dst,
    output logic [1:0]          wb_src,
    output logic                illegal,
    output logic [CNT_W-1:0]    retired
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_J, C_JAL, C_BEQ, C_BNE, C_ADDI, C_ANDI, C_ORI, C_LUI, C_LW, C_SW, C_ILL
    } iclass_t;

    state_t            state_q, state_d;
    iclass_t           cls;
    logic              retire;
    logic [CNT_W-1:0]  retired_q, retired_d;

    always_comb begin
        cls = C_ILL;
        unique case (inst[31:26])
            6'h00:        cls = C_R;
            6'h02:        cls = C_J;
            6'h03:        cls = C_JAL;
            6'h04:        cls = C_BEQ;
            6'h05:        cls = C_BNE;
            6'h08, 6'h09: cls = C_ADDI;
            6'h0C:        cls = C_ANDI;
            6'h0D:        cls = C_ORI;
            6'h0F:        cls = C_LUI;
            6'h23:        cls = C_LW;
            6'h2B:        cls = C_SW;
            default:      cls = C_ILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (cls == C_J || cls == C_JAL) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (cls == C_ILL) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cls == C_BEQ || cls == C_BNE) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (cls == C_LW || cls == C_SW) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (cls == C_SW) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    end

    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_src      = 2'd0;
        alu_op      = '0;
        alu_src_imm = 1'b0;
        reg_we      = 1'b0;
        reg_dst     = 2'd0;
        wb_src      = 2'd0;
        illegal     = 1'b0;
        // Reset forces the idle fetch request regardless of mem_ready.
        if (rst) begin
            mem_req = 1'b1;
        end else begin
            if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
                unique case (cls)
                    C_R:               alu_op = ALU_OP_W'(4);
                    C_ADDI, C_LW, C_SW: begin
                        alu_op      = ALU_OP_W'(0);
                        alu_src_imm = 1'b1;
                    end
                    C_ANDI: begin
                        alu_op      = ALU_OP_W'(2);
                        alu_src_imm = 1'b1;
                    end
                    C_ORI: begin
                        alu_op      = ALU_OP_W'(3);
                        alu_src_imm = 1'b1;
                    end
                    C_BEQ, C_BNE:      alu_op = ALU_OP_W'(1);
                    default:           alu_op = '0;
                endcase
            end
            unique case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_we = 1'b1;
                        pc_we = 1'b1;
                    end
                end
                S_DECODE: begin
                    if (cls == C_J || cls == C_JAL) begin
                        pc_we  = 1'b1;
                        pc_src = 2'd2;
                    end
                    if (cls == C_JAL) begin
                        reg_we  = 1'b1;
                        reg_dst = 2'd2;
                        wb_src  = 2'd3;
                    end
                    if (cls == C_ILL) illegal = 1'b1;
                end
                S_EXEC: begin
                    if ((cls == C_BEQ && zero) || (cls == C_BNE && !zero)) begin
                        pc_we  = 1'b1;
                        pc_src = 2'd1;
                    end
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = (cls == C_SW);
                end
                S_WB: begin
                    reg_we  = 1'b1;
                    reg_dst = (cls == C_R) ? 2'd1 : 2'd0;
                    if (cls == C_LW)       wb_src = 2'd1;
                    else if (cls == C_LUI) wb_src = 2'd2;
                end
                default: ;
            endcase
        end
    end

    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_cu.sv
// Bench for multicycle_cu: per-instruction transaction model (latency,
// event counts, control values) checked against two counter widths.
module tb_multicycle_cu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst;
    logic        zero;
    logic        mem_ready;

    logic        mem_req, mem_we, ir_we, pc_we, alu_src_imm, reg_we, illegal;
    logic [1:0]  pc_src, reg_dst, wb_src;
    logic [2:0]  alu_op;
    logic [31:0] retired;

    logic        w2_mem_req, w2_mem_we, w2_ir_we, w2_pc_we, w2_alu_src_imm, w2_reg_we, w2_illegal;
    logic [1:0]  w2_pc_src, w2_reg_dst, w2_wb_src;
    logic [2:0]  w2_alu_op;
    logic [1:0]  w2_retired;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned ref_cnt  = 0;

    always #5 clk = ~clk;

    multicycle_cu #(.ALU_OP_W(3), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .inst(inst), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we),
        .pc_src(pc_src), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
        .reg_we(reg_we), .reg_dst(reg_dst), .wb_src(wb_src),
        .illegal(illegal), .retired(retired)
    );

    multicycle_cu #(.ALU_OP_W(3), .CNT_W(2)) dut_w2 (
        .clk(clk), .rst(rst), .inst(inst), .zero(zero), .mem_ready(mem_ready),
        .mem_req(w2_mem_req), .mem_we(w2_mem_we), .ir_we(w2_ir_we), .pc_we(w2_pc_we),
        .pc_src(w2_pc_src), .alu_op(w2_alu_op), .alu_src_imm(w2_alu_src_imm),
        .reg_we(w2_reg_we), .reg_dst(w2_reg_dst), .wb_src(w2_wb_src),
        .illegal(w2_illegal), .retired(w2_retired)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_counters();
        check("retired", retired, ref_cnt);
        check("retired_w2", {30'b0, w2_retired}, ref_cnt % 4);
    endtask

    // One instruction from FETCH back to FETCH; fw/mw are memory wait cycles.
    task automatic run_instr(input logic [5:0] op, input logic [25:0] rest,
                             input logic z, input int unsigned fw, input int unsigned mw);
        bit legal, jmp, jal, br, taken, ls, lw, sw, wr;
        int unsigned lat;
        int unsigned e_pc, e_src, e_dst, e_wsrc, e_alu, e_imm, e_mr, e_mw;
        int unsigned n_ir, n_pc, n_rw, n_mr, n_mw, n_ill, acc, wcnt;
        logic [1:0] o_src, o_dst, o_wsrc;
        logic [2:0] o_alu, x_alu;
        logic       o_imm, x_imm;

        legal = 1; jmp = 0; jal = 0; br = 0; ls = 0; lw = 0; sw = 0; wr = 0;
        e_dst = 0; e_wsrc = 0; e_alu = 0; e_imm = 0;
        case (op)
            6'h00: begin wr = 1; e_dst = 1; e_alu = 4; end
            6'h02: jmp = 1;
            6'h03: begin jmp = 1; jal = 1; wr = 1; e_dst = 2; e_wsrc = 3; end
            6'h04, 6'h05: begin br = 1; e_alu = 1; end
            6'h08, 6'h09: begin wr = 1; e_imm = 1; end
            6'h0C: begin wr = 1; e_alu = 2; e_imm = 1; end
            6'h0D: begin wr = 1; e_alu = 3; e_imm = 1; end
            6'h0F: begin wr = 1; e_wsrc = 2; end
            6'h23: begin ls = 1; lw = 1; wr = 1; e_wsrc = 1; e_imm = 1; end
            6'h2B: begin ls = 1; sw = 1; e_imm = 1; end
            default: legal = 0;
        endcase
        taken = (op == 6'h04 && z) || (op == 6'h05 && !z);
        if (!legal || jmp) lat = 2;
        else if (br)       lat = 3;
        else if (lw)       lat = 5;
        else               lat = 4;
        lat += fw + (ls ? mw : 0);
        e_pc  = 1 + ((jmp || taken) ? 1 : 0);
        e_src = jmp ? 2 : (taken ? 1 : 0);
        e_mr  = fw + 1 + (ls ? mw + 1 : 0);
        e_mw  = sw ? mw + 1 : 0;

        n_ir = 0; n_pc = 0; n_rw = 0; n_mr = 0; n_mw = 0; n_ill = 0; acc = 0; wcnt = 0;
        o_src = 0; o_dst = 0; o_wsrc = 0; o_alu = 0; o_imm = 0; x_alu = 0; x_imm = 0;
        for (int unsigned c = 0; c < lat; c++) begin
            @(negedge clk);
            if (c == 0) begin
                inst = {op, rest};
                zero = z;
            end
            mem_ready = 1'b0;
            #1;
            if (mem_req) begin
                if (wcnt == ((acc == 0) ? fw : mw)) begin
                    mem_ready = 1'b1;
                    acc++;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            if (ir_we) n_ir++;
            if (pc_we) begin n_pc++; o_src = pc_src; end
            if (reg_we) begin
                n_rw++; o_dst = reg_dst; o_wsrc = wb_src; o_alu = alu_op; o_imm = alu_src_imm;
            end
            if (mem_req) n_mr++;
            if (mem_we) n_mw++;
            if (illegal) n_ill++;
            if (c == fw + 2) begin x_alu = alu_op; x_imm = alu_src_imm; end
        end

        check("ir_we_count", n_ir, 1);
        check("pc_we_count", n_pc, e_pc);
        check("pc_src_last", {30'b0, o_src}, e_src);
        check("reg_we_count", n_rw, wr ? 1 : 0);
        check("mem_req_cycles", n_mr, e_mr);
        check("mem_we_cycles", n_mw, e_mw);
        check("illegal_count", n_ill, legal ? 0 : 1);
        if (wr) begin
            check("reg_dst", {30'b0, o_dst}, e_dst);
            check("wb_src", {30'b0, o_wsrc}, e_wsrc);
            check("wb_alu_op", {29'b0, o_alu}, jal ? 0 : e_alu);
            check("wb_alu_imm", {31'b0, o_imm}, jal ? 0 : e_imm);
        end
        if (legal && !jmp) begin
            check("exec_alu_op", {29'b0, x_alu}, e_alu);
            check("exec_alu_imm", {31'b0, x_imm}, e_imm);
        end
        if (legal) ref_cnt++;
        @(posedge clk);
        #1;
        check_counters();
        check("next_fetch_req", {31'b0, mem_req}, 1);
    endtask

    initial begin
        logic [5:0] op;
        logic [5:0] legal_ops [12];
        legal_ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
                      6'h09, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};

        rst = 1'b1; mem_ready = 1'b0; inst = '0; zero = 1'b0;
        @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        check("rst_mem_req", {31'b0, mem_req}, 1);
        check("rst_ir_we", {31'b0, ir_we}, 0);
        check("rst_pc_we", {31'b0, pc_we}, 0);
        check_counters();
        @(negedge clk);
        rst = 1'b0; mem_ready = 1'b0;

        // Directed: add with 3 fetch waits, lw/sw with waits, branches, jal, illegal.
        run_instr(6'h00, 26'h0000020, 1'b0, 3, 0);
        run_instr(6'h23, 26'h1234567, 1'b0, 0, 2);
        run_instr(6'h2B, 26'h0abcdef, 1'b0, 0, 1);
        run_instr(6'h04, 26'h0000010, 1'b1, 0, 0);
        run_instr(6'h05, 26'h0000010, 1'b1, 0, 0);
        run_instr(6'h05, 26'h0000010, 1'b0, 1, 0);
        run_instr(6'h03, 26'h0000100, 1'b0, 0, 0);
        run_instr(6'h3F, 26'h3ffffff, 1'b0, 0, 0);
        run_instr(6'h0F, 26'h000beef, 1'b0, 0, 0);
        run_instr(6'h0D, 26'h0000f0f, 1'b0, 2, 0);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 4) == 0) op = 6'($urandom);
            else op = legal_ops[$urandom_range(0, 11)];
            run_instr(op, 26'($urandom), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 2), $urandom_range(0, 2));
        end

        // Reset in the middle of lw's MEM phase.
        @(negedge clk);
        inst = {6'h23, 26'h0000004}; mem_ready = 1'b1;
        @(negedge clk); mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("mid_mem_req", {31'b0, mem_req}, 1);
        rst = 1'b1;
        #1;
        ref_cnt = 0;
        check_counters();
        check("mid_rst_mem_we", {31'b0, mem_we}, 0);
        check("mid_rst_reg_we", {31'b0, reg_we}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_fetch", {31'b0, mem_req}, 1);
        check("post_rst_mem_we", {31'b0, mem_we}, 0);

        for (int i = 0; i < 6; i++)
            run_instr(legal_ops[$urandom_range(0, 11)], 26'($urandom), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 1), $urandom_range(0, 1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
